// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Define UART_RX_PARITY_CHECK_EN to drive parity_err from the parity check.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    state_t          state;
    state_t          state_nxt;
    logic            rx_meta;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            tick;
    logic            valid_d;
    logic            ferr_d;

    // Start bit is resampled at half a period, every other bit at a full period
    assign tick = (state == START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_s) state_nxt = START;
            START:     if (tick) state_nxt = rx_s ? IDLE : DATA;
            DATA:      if (tick && bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY:    if (tick) state_nxt = STOP;
            STOP:      if (tick) state_nxt = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output decode: busy plus the one-cycle-early result strobes
    always_comb begin
        busy    = (state != IDLE);
        valid_d = (state == STOP) && tick && rx_s;
        ferr_d  = (state == STOP) && tick && !rx_s;
    end

    // Synchronizer, bit timing, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            cnt       <= '0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            data_out  <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx_in;
            rx_s      <= rx_meta;
            rx_valid  <= valid_d;
            frame_err <= ferr_d;
            if (state == IDLE || state == WAIT_HIGH || tick)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == DATA) begin
                if (tick) begin
                    shreg   <= {rx_s, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                bit_cnt <= 3'd0;
            end
            if (valid_d)
                data_out <= shreg;
        end
    end

`ifdef UART_RX_PARITY_CHECK_EN
    logic par_bit;

    // Capture the parity bit and flag a mismatch alongside rx_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == PARITY && tick)
                par_bit <= rx_s;
            parity_err <= valid_d & (^shreg ^ par_bit);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=16.
// Stimulus pushes expected bytes; a negedge monitor pops and compares.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    typedef struct {
        logic [7:0] d;
        logic       p;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   valid_cnt = 0;
    int   ferr_cnt = 0;
    bit   busy_seen = 0;
    bit   prev_valid = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic exp_p(input logic [7:0] d, input logic par);
`ifdef UART_RX_PARITY_CHECK_EN
        return (^d) ^ par;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stop);
        exp_t e;
        if (stop) begin
            e.d = d;
            e.p = exp_p(d, par);
            q.push_back(e);
        end
        rx_in = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            wait_cyc(CPB);
        end
        rx_in = par;
        wait_cyc(CPB);
        rx_in = stop;
        wait_cyc(CPB);
    endtask

    // Monitor: pops the scoreboard on every rx_valid pulse
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid) begin
            valid_cnt++;
            if (prev_valid) begin
                checks++;
                failures++;
                $display("FAIL valid_width rx_valid high two cycles");
            end
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid data_out=%h", data_out);
            end else begin
                e = q.pop_front();
                checks++;
                if (data_out !== e.d) begin
                    failures++;
                    $display("FAIL data got=%h want=%h", data_out, e.d);
                end
                checks++;
                if (parity_err !== e.p) begin
                    failures++;
                    $display("FAIL parity_err got=%b want=%b data=%h",
                             parity_err, e.p, e.d);
                end
            end
        end
        prev_valid = rx_valid;
        if (frame_err) ferr_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    initial begin
        int n;
        wait_cyc(3);
        @(negedge clk);
        chk("rst_data", data_out, 8'h00);
        chk("rst_valid", rx_valid, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cyc(5);

        send_frame(8'hA5, 1'b0, 1'b1);
        wait_cyc(5);
        send_frame(8'h01, 1'b0, 1'b1);
        wait_cyc(10);

        busy_seen = 1'b0;
        rx_in = 1'b0;
        wait_cyc(4);
        rx_in = 1'b1;
        wait_cyc(30);
        @(negedge clk);
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_busy_idle", busy, 0);
        chk("glitch_data_hold", data_out, 8'h01);
        chk("glitch_valid_cnt", valid_cnt, 2);
        chk("glitch_ferr_cnt", ferr_cnt, 0);
        @(posedge clk);
        #1;

        send_frame(8'h3C, 1'b0, 1'b0);
        wait_cyc(40);
        @(negedge clk);
        chk("ferr_busy_held", busy, 1);
        chk("ferr_cnt", ferr_cnt, 1);
        @(posedge clk);
        #1;
        rx_in = 1'b1;
        n = 0;
        while (busy && n < 8) begin
            wait_cyc(1);
            n++;
        end
        chk("ferr_busy_release", busy, 0);
        chk("ferr_no_valid", valid_cnt, 2);
        chk("ferr_data_hold", data_out, 8'h01);
        wait_cyc(5);
        send_frame(8'h55, 1'b0, 1'b1);

        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b1);
        wait_cyc(10);
        chk("b2b_valid_cnt", valid_cnt, 6);

        rx_in = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_in = 1'b1 & 8'h77 >> i;
            wait_cyc(CPB);
        end
        rx_in = 1'b1;
        wait_cyc(8);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_data", data_out, 8'h00);
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        wait_cyc(40);
        chk("mid_rst_valid_cnt", valid_cnt, 6);
        chk("mid_rst_ferr_cnt", ferr_cnt, 1);
        chk("mid_rst_idle", busy, 0);
        chk("mid_rst_data_hold", data_out, 8'h00);
        send_frame(8'h12, 1'b0, 1'b1);
        wait_cyc(20);

        chk("sb_empty", q.size(), 0);
        chk("total_valid", valid_cnt, 7);
        chk("total_ferr", ferr_cnt, 1);
        chk("final_data", data_out, 8'h12);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
